// File: rtl/bcd_event_counter_disp.sv
// Prescaled BCD event counter with seven-segment display and status LEDs.
// A prescaler divides CLOCK_50 into count ticks. Each tick moves a DIGITS-wide
// BCD counter up or down. The counter supports clear, parallel load and a
// display freeze, and its value drives active-low seven-segment displays
// through a display register.
module bcd_event_counter_disp #(
    parameter int DIGITS  = 4,
    parameter int CLK_DIV = 50000000,
    parameter int DIV_W   = 26
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  dir,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  freeze,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic [7*DIGITS-1:0]   HEX,
    output logic [3:0]            LEDR
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    // Active-low segment pattern {g,f,e,d,c,b,a}. Codes above 9 cannot
    // occur, so they simply blank the digit.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic [DIV_W-1:0]    presc_q, presc_d;
    logic [4*DIGITS-1:0] count_q, count_d;
    logic [7*DIGITS-1:0] hex_q, hex_d;
    logic                tick_pulse_q, tick_pulse_d;
    logic                wrap_pulse_q, wrap_pulse_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;

    logic                tick;
    logic [4*DIGITS-1:0] inc_bcd;
    logic [4*DIGITS-1:0] dec_bcd;
    logic [4*DIGITS-1:0] load_sat;
    logic [7*DIGITS-1:0] hex_dec;
    logic                all_nine;
    logic                all_zero;

    // The tick fires on the last prescaler state, and only while enabled.
    assign tick = en && (presc_q == DIV_LAST);

    // Per-digit BCD increment and decrement, load saturation and segment decode.
    always_comb begin
        logic       carry;
        logic       borrow;
        logic [3:0] dig;
        logic [3:0] ld;
        carry    = 1'b1;
        borrow   = 1'b1;
        inc_bcd  = '0;
        dec_bcd  = '0;
        load_sat = '0;
        hex_dec  = '0;
        all_nine = 1'b1;
        all_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            dig = count_q[4*i +: 4];
            ld  = load_val[4*i +: 4];
            if (dig != 4'd9) all_nine = 1'b0;
            if (dig != 4'd0) all_zero = 1'b0;
            // Increment: a 9 rolls to 0 and passes the carry on.
            if (carry) begin
                if (dig == 4'd9) begin
                    inc_bcd[4*i +: 4] = 4'd0;
                end else begin
                    inc_bcd[4*i +: 4] = dig + 4'd1;
                    carry = 1'b0;
                end
            end else begin
                inc_bcd[4*i +: 4] = dig;
            end
            // Decrement: a 0 rolls to 9 and passes the borrow on.
            if (borrow) begin
                if (dig == 4'd0) begin
                    dec_bcd[4*i +: 4] = 4'd9;
                end else begin
                    dec_bcd[4*i +: 4] = dig - 4'd1;
                    borrow = 1'b0;
                end
            end else begin
                dec_bcd[4*i +: 4] = dig;
            end
            load_sat[4*i +: 4] = (ld > 4'd9) ? 4'd9 : ld;
            hex_dec[7*i +: 7]  = seg7(dig);
        end
    end

    // Next-state selection: clear beats load, and load beats a tick.
    always_comb begin
        presc_d      = presc_q;
        count_d      = count_q;
        tick_pulse_d = 1'b0;
        wrap_pulse_d = 1'b0;
        ovf_d        = ovf_q;
        unf_d        = unf_q;
        if (clear) begin
            presc_d = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else if (load) begin
            presc_d = '0;
            count_d = load_sat;
        end else if (tick) begin
            presc_d      = '0;
            tick_pulse_d = 1'b1;
            if (!dir) begin
                count_d = inc_bcd;
                if (all_nine) begin
                    wrap_pulse_d = 1'b1;
                    ovf_d        = 1'b1;
                end
            end else begin
                count_d = dec_bcd;
                if (all_zero) begin
                    wrap_pulse_d = 1'b1;
                    unf_d        = 1'b1;
                end
            end
        end else if (en) begin
            presc_d = presc_q + DIV_W'(1);
        end
    end

    // The display register follows the live count unless it is frozen.
    always_comb begin
        hex_d = freeze ? hex_q : hex_dec;
    end

    // State registers, with a synchronous reset that overrides everything.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            presc_q      <= '0;
            count_q      <= '0;
            hex_q        <= {DIGITS{7'b1000000}};
            tick_pulse_q <= 1'b0;
            wrap_pulse_q <= 1'b0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            count_q      <= count_d;
            hex_q        <= hex_d;
            tick_pulse_q <= tick_pulse_d;
            wrap_pulse_q <= wrap_pulse_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
        end
    end

    assign count_bcd = count_q;
    assign HEX       = hex_q;
    assign LEDR      = {unf_q, ovf_q, wrap_pulse_q, tick_pulse_q};

endmodule

// File: tb/tb_bcd_event_counter_disp.sv
// Directed bench for bcd_event_counter_disp with two digits and a divide-by-4 prescaler.
module tb_bcd_event_counter_disp;

    localparam int DIGITS  = 2;
    localparam int CLK_DIV = 4;
    localparam int DIV_W   = 3;

    logic        clk;
    logic        reset;
    logic        en;
    logic        dir;
    logic        clear;
    logic        load;
    logic [7:0]  load_val;
    logic        freeze;
    logic [7:0]  count_bcd;
    logic [13:0] hex;
    logic [3:0]  ledr;

    int n_checks;
    int n_fail;

    bcd_event_counter_disp #(
        .DIGITS (DIGITS),
        .CLK_DIV(CLK_DIV),
        .DIV_W  (DIV_W)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .en       (en),
        .dir      (dir),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .freeze   (freeze),
        .count_bcd(count_bcd),
        .HEX      (hex),
        .LEDR     (ledr)
    );

    // Clock and initial input levels.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference segment patterns, written out by hand from the decode table.
    function automatic logic [6:0] ref_seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; dir = 1'b0; clear = 1'b0; load = 1'b0;
        load_val = 8'h00; freeze = 1'b0;
        step(2);
        n_checks++;
        if (count_bcd !== 8'h00) begin
            n_fail++; $display("FAIL reset_count got=%h exp=00", count_bcd);
        end
        n_checks++;
        if (ledr !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ledr got=%b exp=0000", ledr);
        end
        n_checks++;
        if (hex !== {ref_seg(0), ref_seg(0)}) begin
            n_fail++; $display("FAIL reset_hex got=%b exp=%b", hex, {ref_seg(0), ref_seg(0)});
        end
    endtask

    task automatic test_count_up();
        reset = 1'b0; en = 1'b1; dir = 1'b0;
        step(3);
        n_checks++;
        if (count_bcd !== 8'h00) begin
            n_fail++; $display("FAIL up_before_tick got=%h exp=00", count_bcd);
        end
        step(1);
        n_checks++;
        if (count_bcd !== 8'h01 || ledr !== 4'b0001) begin
            n_fail++; $display("FAIL up_first_tick count=%h ledr=%b exp count=01 ledr=0001", count_bcd, ledr);
        end
        step(1);
        n_checks++;
        if (hex !== {ref_seg(0), ref_seg(1)} || ledr !== 4'b0000) begin
            n_fail++; $display("FAIL up_hex_lag hex=%b ledr=%b exp hex=%b ledr=0000", hex, ledr, {ref_seg(0), ref_seg(1)});
        end
        step(35);
        n_checks++;
        if (count_bcd !== 8'h10 || hex !== {ref_seg(0), ref_seg(9)}) begin
            n_fail++; $display("FAIL up_digit_carry count=%h hex=%b exp count=10 hex=%b", count_bcd, hex, {ref_seg(0), ref_seg(9)});
        end
        step(1);
        n_checks++;
        if (hex !== {ref_seg(1), ref_seg(0)}) begin
            n_fail++; $display("FAIL up_hex_10 got=%b exp=%b", hex, {ref_seg(1), ref_seg(0)});
        end
    endtask

    task automatic test_wrap_up();
        load = 1'b1; load_val = 8'h98;
        step(1);
        load = 1'b0;
        n_checks++;
        if (count_bcd !== 8'h98) begin
            n_fail++; $display("FAIL wrap_up_load got=%h exp=98", count_bcd);
        end
        step(4);
        n_checks++;
        if (count_bcd !== 8'h99 || ledr !== 4'b0001) begin
            n_fail++; $display("FAIL wrap_up_99 count=%h ledr=%b exp count=99 ledr=0001", count_bcd, ledr);
        end
        step(4);
        n_checks++;
        if (count_bcd !== 8'h00 || ledr !== 4'b0111) begin
            n_fail++; $display("FAIL wrap_up_00 count=%h ledr=%b exp count=00 ledr=0111", count_bcd, ledr);
        end
        step(1);
        n_checks++;
        if (ledr !== 4'b0100) begin
            n_fail++; $display("FAIL wrap_up_sticky got=%b exp=0100", ledr);
        end
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        n_checks++;
        if (count_bcd !== 8'h00 || ledr !== 4'b0000) begin
            n_fail++; $display("FAIL wrap_up_clear count=%h ledr=%b exp count=00 ledr=0000", count_bcd, ledr);
        end
    endtask

    task automatic test_wrap_down();
        dir = 1'b1;
        step(4);
        n_checks++;
        if (count_bcd !== 8'h99 || ledr !== 4'b1011) begin
            n_fail++; $display("FAIL wrap_down count=%h ledr=%b exp count=99 ledr=1011", count_bcd, ledr);
        end
        step(1);
        n_checks++;
        if (ledr !== 4'b1000) begin
            n_fail++; $display("FAIL wrap_down_sticky got=%b exp=1000", ledr);
        end
    endtask

    task automatic test_saturation();
        en = 1'b0;
        load = 1'b1; load_val = 8'hC3;
        step(1);
        n_checks++;
        if (count_bcd !== 8'h93 || ledr !== 4'b1000) begin
            n_fail++; $display("FAIL sat_c3 count=%h ledr=%b exp count=93 ledr=1000", count_bcd, ledr);
        end
        load_val = 8'h5A;
        step(1);
        load = 1'b0;
        n_checks++;
        if (count_bcd !== 8'h59) begin
            n_fail++; $display("FAIL sat_5a got=%h exp=59", count_bcd);
        end
    endtask

    task automatic test_freeze();
        en = 1'b1; dir = 1'b0;
        load = 1'b1; load_val = 8'h05;
        step(1);
        load = 1'b0;
        step(1);
        n_checks++;
        if (hex !== {ref_seg(0), ref_seg(5)}) begin
            n_fail++; $display("FAIL freeze_pre hex=%b exp=%b", hex, {ref_seg(0), ref_seg(5)});
        end
        freeze = 1'b1;
        step(39);
        n_checks++;
        if (count_bcd !== 8'h15 || hex !== {ref_seg(0), ref_seg(5)}) begin
            n_fail++; $display("FAIL freeze_hold count=%h hex=%b exp count=15 hex=%b", count_bcd, hex, {ref_seg(0), ref_seg(5)});
        end
        freeze = 1'b0;
        step(1);
        n_checks++;
        if (hex !== {ref_seg(1), ref_seg(5)}) begin
            n_fail++; $display("FAIL freeze_release hex=%b exp=%b", hex, {ref_seg(1), ref_seg(5)});
        end
    endtask

    task automatic test_clear_with_tick();
        step(2);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        n_checks++;
        if (count_bcd !== 8'h00 || ledr !== 4'b0000) begin
            n_fail++; $display("FAIL clear_tick count=%h ledr=%b exp count=00 ledr=0000", count_bcd, ledr);
        end
        step(3);
        n_checks++;
        if (count_bcd !== 8'h00) begin
            n_fail++; $display("FAIL clear_presc_restart got=%h exp=00", count_bcd);
        end
        step(1);
        n_checks++;
        if (count_bcd !== 8'h01) begin
            n_fail++; $display("FAIL clear_first_tick got=%h exp=01", count_bcd);
        end
    endtask

    task automatic test_reset_mid();
        step(2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        n_checks++;
        if (count_bcd !== 8'h00 || ledr !== 4'b0000 || hex !== {ref_seg(0), ref_seg(0)}) begin
            n_fail++; $display("FAIL reset_mid count=%h ledr=%b hex=%b exp 00/0000/%b", count_bcd, ledr, hex, {ref_seg(0), ref_seg(0)});
        end
        step(3);
        n_checks++;
        if (count_bcd !== 8'h00) begin
            n_fail++; $display("FAIL reset_mid_early got=%h exp=00", count_bcd);
        end
        step(1);
        n_checks++;
        if (count_bcd !== 8'h01) begin
            n_fail++; $display("FAIL reset_mid_first_tick got=%h exp=01", count_bcd);
        end
    endtask

    task automatic test_enable_hold();
        step(2);
        en = 1'b0;
        step(10);
        n_checks++;
        if (count_bcd !== 8'h01 || ledr[0] !== 1'b0) begin
            n_fail++; $display("FAIL en_hold count=%h tick=%b exp count=01 tick=0", count_bcd, ledr[0]);
        end
        en = 1'b1;
        step(1);
        n_checks++;
        if (count_bcd !== 8'h01) begin
            n_fail++; $display("FAIL en_resume_early got=%h exp=01", count_bcd);
        end
        step(1);
        n_checks++;
        if (count_bcd !== 8'h02) begin
            n_fail++; $display("FAIL en_resume_tick got=%h exp=02", count_bcd);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_count_up();
        test_wrap_up();
        test_wrap_down();
        test_saturation();
        test_freeze();
        test_clear_with_tick();
        test_reset_mid();
        test_enable_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_event_counter_disp.md
Name: bcd_event_counter_disp

Overview:
- Parametrised successor to the single-channel pulse counter and 4-digit screen pair.
- Prescales CLOCK_50 into a tick and counts ticks in a DIGITS-wide decimal (BCD) counter.
- Supports up/down mode, synchronous clear, parallel load and display freeze.
- Drives DIGITS active-low seven-segment displays plus status LEDs directly from registers. Sits at board top level, fed by switches/keys.

Parameters:
- DIGITS, 4, number of BCD digits and seven-segment displays (1..8).
- CLK_DIV, 50000000, CLOCK_50 cycles per count tick (>=1; 1 = tick every cycle).
- DIV_W, 26, prescaler width; must satisfy 2^DIV_W >= CLK_DIV.

Ports:
- CLOCK_50 in 1: system clock, all logic on rising edge.
- reset in 1: synchronous, active-high; highest priority.
- en in 1: 1 = prescaler runs and ticks are counted; 0 = prescaler and counter hold.
- dir in 1: 0 = count up, 1 = count down; sampled on tick cycle.
- clear in 1: synchronous clear of counter, prescaler and sticky flags.
- load in 1: synchronous load of load_val into counter; prescaler restarts at 0.
- load_val in 4*DIGITS: BCD load value; any nibble >9 is loaded as 9.
- freeze in 1: 1 = display registers hold; counting continues underneath.
- count_bcd out 4*DIGITS: live BCD count, digit 0 in [3:0].
- HEX out 7*DIGITS: active-low segments {g,f,e,d,c,b,a}, digit 0 in [6:0].
- LEDR out 4: [0] tick pulse, [1] wrap pulse, [2] sticky overflow, [3] sticky underflow.

Behaviour:
- Reset (reset=1 at edge):
  - prescaler = 0; count_bcd = 0; LEDR = 0.
  - Display registers = 0, so every HEX digit = 7'b1000000 ("0").
  - Applies regardless of all other inputs.
- Priority per cycle: reset > clear > load > tick.
  - clear: count = 0, prescaler = 0, LEDR[3:0] = 0; display registers are not forced, see display rules.
  - load: count = saturated load_val, prescaler = 0, flags untouched, no tick that cycle.
- Prescaler:
  - When en=1, increments each cycle.
  - When prescaler == CLK_DIV-1: wraps to 0 and asserts internal tick for that cycle.
  - en=0 freezes the prescaler value; no tick.
  - CLK_DIV=1: tick every en cycle.
- Tick, up (dir=0): BCD increment.
  - Digit 9 -> 0 with carry into the next digit.
  - All digits 9 -> all 0: wrap pulse, LEDR[2] set sticky.
- Tick, down (dir=1): BCD decrement.
  - Digit 0 -> 9 with borrow.
  - All 0 -> all 9: wrap pulse, LEDR[3] set sticky.
- Timing of tick-driven outputs:
  - count_bcd updates at the tick edge, i.e. visible the cycle after the prescaler reached CLK_DIV-1.
  - LEDR[0] and LEDR[1] are registered one-cycle pulses aligned with the count_bcd update.
  - Sticky flags are cleared only by reset or clear.
- Invariant: count_bcd never contains a nibble >9.
- Display path:
  - When freeze=0, the display register copies count_bcd each cycle. HEX therefore lags count_bcd by exactly 1 cycle (registered decode).
  - When freeze=1, the display register holds. On release, it resumes one cycle later.
  - clear/load while frozen leave HEX unchanged until freeze falls.
- Decode (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Leading zeros are displayed, not blanked.
- Mid-operation changes:
  - dir changes take effect on the next tick only.
  - en falling mid-period resumes from the held prescaler value.

Test Plan:
- DIGITS=2, CLK_DIV=4, reset 2 cycles then en=1, dir=0 -> count_bcd 00,01,02… every 4 cycles; at 09->10 low digit wraps; HEX0=1000000, HEX1=1111001 one cycle after count_bcd=8'h10.
- load 8'h98, dir=0, run 2 ticks -> 99 then 00. LEDR[1] pulses once with the 00 update; LEDR[2]=1 and stays set. clear -> count 00, LEDR=0.
- Count 00, dir=1, 1 tick -> 99, LEDR[3]=1, LEDR[1] one-cycle pulse.
- load_val=8'hC3 -> count_bcd=8'h93 (saturation).
- freeze=1 at count 05, run 10 ticks -> HEX stays "05" while count_bcd reaches 15; freeze=0 -> HEX shows 15 one cycle later.
- clear and tick in the same cycle -> count 00, prescaler 0. Assert reset mid-period with en=1 -> everything 0 next cycle; first tick arrives CLK_DIV cycles after reset release.
